// File: rtl/keccak_pkg.sv
// Shared types, constants and LFSR helpers for
// the Keccak round-constant generator.
package keccak_pkg;

  localparam logic [7:0] LFSR_TAPS = 8'h71;
  localparam logic [7:0] LFSR_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rc_state_t;

  function automatic int nr_default(input int w);
    return 12 + 2 * $clog2(w);
  endfunction

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] s
  );
    return {s[6:0], 1'b0} ^
           (s[7] ? LFSR_TAPS : 8'h00);
  endfunction

  function automatic logic [7:0] lfsr_skip(
    input logic [7:0] s,
    input int         n
  );
    logic [7:0] t;
    t = s;
    for (int i = 0; i < n; i++) begin
      t = lfsr_step(t);
    end
    return t;
  endfunction

endpackage

// File: rtl/keccak_rc_step.sv
// One round worth of LFSR output: the sparse rc lane
// plus the LFSR state seven steps further on.
module keccak_rc_step
  import keccak_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [7:0]   state,
  output logic [W-1:0] rc,
  output logic [7:0]   state_next
);

  localparam int L = $clog2(W);

  logic [63:0] rc_full;
  logic [7:0]  t;

  // Bit j of the LFSR stream lands on lane bit 2^j-1.
  always_comb begin
    rc_full = '0;
    t       = state;
    for (int j = 0; j < 7; j++) begin
      if (j <= L) begin
        rc_full[(1 << j) - 1] = t[0];
      end
      t = lfsr_step(t);
    end
    state_next = t;
  end

  assign rc = rc_full[W-1:0];

endmodule

// File: rtl/keccak_rc_gen.sv
// Sequential iota round-constant generator with
// round index and valid/last/done handshake.
module keccak_rc_gen
  import keccak_pkg::*;
#(
  parameter int W  = 64,
  parameter int NR = nr_default(W)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         advance,
  output logic [W-1:0] rc,
  output logic [4:0]   round,
  output logic         valid,
  output logic         last,
  output logic         done
);

  localparam int L   = $clog2(W);
  localparam int IR0 = 12 + 2 * L - NR;

  localparam logic [7:0] SEED =
    lfsr_skip(LFSR_INIT, 7 * IR0);
  localparam logic [4:0] LAST_ROUND = 5'(NR - 1);

  rc_state_t    state;
  rc_state_t    state_n;
  logic [7:0]   lfsr;
  logic [7:0]   lfsr_n;
  logic [4:0]   round_n;
  logic [4:0]   round_inc;
  logic [W-1:0] rc_n;
  logic         valid_n;
  logic         last_n;
  logic         done_n;

  logic [7:0]   step_in;
  logic [W-1:0] step_rc;
  logic [7:0]   step_next;

  // A start always reloads from the seed.
  assign step_in   = start ? SEED : lfsr;
  assign round_inc = round + 5'd1;

  keccak_rc_step #(
    .W (W)
  ) u_step (
    .state      (step_in),
    .rc         (step_rc),
    .state_next (step_next)
  );

  // Next-state and registered-output selection.
  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    round_n = round;
    rc_n    = rc;
    valid_n = valid;
    last_n  = last;
    done_n  = 1'b0;
    if (start) begin
      state_n = RUN;
      lfsr_n  = step_next;
      round_n = 5'd0;
      rc_n    = step_rc;
      valid_n = 1'b1;
      last_n  = (LAST_ROUND == 5'd0);
    end else begin
      unique case (state)
        IDLE: begin
        end
        RUN: begin
          if (advance) begin
            if (round == LAST_ROUND) begin
              state_n = DONE;
              round_n = 5'd0;
              rc_n    = '0;
              valid_n = 1'b0;
              last_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              lfsr_n  = step_next;
              round_n = round_inc;
              rc_n    = step_rc;
              last_n  = (round_inc == LAST_ROUND);
            end
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      lfsr  <= LFSR_INIT;
      round <= 5'd0;
      rc    <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      lfsr  <= lfsr_n;
      round <= round_n;
      rc    <= rc_n;
      valid <= valid_n;
      last  <= last_n;
      done  <= done_n;
    end
  end

endmodule
